sram_like_responder: RTL and testbench

SRAM_LIKE_RESPONDER -- requirements
Module: sram_like_responder

---
 rtl/sram_like_responder.sv | 119 +++++++++++
 tb/tb_sram_like_responder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_responder.sv
// sram_like_responder: SRAM-like target with an internal word memory, a
// fixed-latency in-order response queue and a test hook to stall acceptance.
module sram_like_responder #(
  parameter int MEM_AW  = 12,
  parameter int LATENCY = 2,
  parameter int MAX_OUT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        stall,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  logic [31:0]       mem [2**MEM_AW];
  logic [MEM_AW-1:0] idx;
  logic [31:0]       rd_word;

  logic [31:0]   q_data [MAX_OUT];
  logic          q_wr   [MAX_OUT];
  logic [LW-1:0] q_cnt  [MAX_OUT];
  logic [31:0]   n_data [MAX_OUT];
  logic          n_wr   [MAX_OUT];
  logic [LW-1:0] n_cnt  [MAX_OUT];
  logic [LW-1:0] aged   [MAX_OUT];

  logic [CW-1:0] outstanding;
  logic [CW-1:0] n_outstanding;
  logic [CW-1:0] slot;
  logic          accept;
  logic          retire;

  // size and the aliased address bits carry no function here
  logic unused_bits;
  assign unused_bits = ^{size, addr[31:MEM_AW+2], addr[1:0]};

  assign idx     = addr[MEM_AW+1:2];
  assign rd_word = mem[idx];

  // Head of the queue retires once its latency counter has run out
  always_comb begin
    retire  = (outstanding != '0) && (q_cnt[0] == '0);
    data_ok = retire;
    addr_ok = resetn && !stall && ((outstanding < CW'(MAX_OUT)) || retire);
    accept  = req && addr_ok;
    rdata   = (retire && !q_wr[0]) ? q_data[0] : '0;
  end

  // Byte-lane masked memory write at the acceptance edge; contents survive reset
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Next queue contents: age all counters, shift on retire, append on accept
  always_comb begin
    for (int unsigned i = 0; i < MAX_OUT; i++) begin
      aged[i]   = (q_cnt[i] != '0) ? q_cnt[i] - LW'(1) : '0;
      n_data[i] = q_data[i];
      n_wr[i]   = q_wr[i];
      n_cnt[i]  = aged[i];
    end
    if (retire) begin
      for (int unsigned i = 0; i + 1 < MAX_OUT; i++) begin
        n_data[i] = q_data[i+1];
        n_wr[i]   = q_wr[i+1];
        n_cnt[i]  = aged[i+1];
      end
    end
    slot = outstanding - CW'(retire);
    if (accept) begin
      for (int unsigned i = 0; i < MAX_OUT; i++) begin
        if (slot == CW'(i)) begin
          n_data[i] = rd_word;
          n_wr[i]   = wr;
          n_cnt[i]  = LW'(LATENCY - 1);
        end
      end
    end
    case ({accept, retire})
      2'b10:   n_outstanding = outstanding + CW'(1);
      2'b01:   n_outstanding = outstanding - CW'(1);
      default: n_outstanding = outstanding;
    endcase
  end

  // Queue and occupancy registers; reset discards every pending response
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      outstanding <= '0;
      for (int unsigned i = 0; i < MAX_OUT; i++) begin
        q_data[i] <= '0;
        q_wr[i]   <= 1'b0;
        q_cnt[i]  <= '0;
      end
    end else begin
      outstanding <= n_outstanding;
      for (int unsigned i = 0; i < MAX_OUT; i++) begin
        q_data[i] <= n_data[i];
        q_wr[i]   <= n_wr[i];
        q_cnt[i]  <= n_cnt[i];
      end
    end
  end

endmodule

// File: tb/tb_sram_like_responder.sv
// Directed self-checking bench for sram_like_responder: one instance with
// LATENCY=2/MAX_OUT=2 and one with LATENCY=4/MAX_OUT=2.
module tb_sram_like_responder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req, wr, stall;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;

  logic        req4, wr4, stall4;
  logic [1:0]  size4;
  logic [3:0]  wstrb4;
  logic [31:0] addr4, wdata4;
  logic        addr_ok4, data_ok4;
  logic [31:0] rdata4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sram_like_responder #(.MEM_AW(12), .LATENCY(2), .MAX_OUT(2)) dut (
    .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size),
    .wstrb(wstrb), .addr(addr), .wdata(wdata), .stall(stall),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
  );

  sram_like_responder #(.MEM_AW(12), .LATENCY(4), .MAX_OUT(2)) dut4 (
    .clk(clk), .resetn(resetn), .req(req4), .wr(wr4), .size(size4),
    .wstrb(wstrb4), .addr(addr4), .wdata(wdata4), .stall(stall4),
    .addr_ok(addr_ok4), .data_ok(data_ok4), .rdata(rdata4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs are driven just after the posedge, outputs sampled at the negedge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    req = r; wr = w; addr = a; wdata = d; wstrb = s;
    @(negedge clk);
  endtask

  task automatic expect_resp(input string tag, input logic ao, input logic dok,
                             input logic [31:0] rd);
    check({tag, ".addr_ok"}, {31'b0, addr_ok}, {31'b0, ao});
    check({tag, ".data_ok"}, {31'b0, data_ok}, {31'b0, dok});
    check({tag, ".rdata"}, rdata, rd);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // dut4 schedule for continuous requests with LATENCY=4, MAX_OUT=2
  logic        e4_ao  [11];
  logic        e4_dok [11];
  logic [31:0] e4_rd  [11];
  logic [31:0] l4_addr [4];
  logic [31:0] l4_data [4];
  logic        l4_wr   [4];

  initial begin
    int k;
    e4_ao  = '{1,1,0,0,1,1,0,0,1,1,1};
    e4_dok = '{0,0,0,0,1,1,0,0,1,1,0};
    e4_rd  = '{0,0,0,0,0,0,0,0,32'hAAAA0000,32'hBBBB1111,0};
    l4_addr = '{32'h0, 32'h4, 32'h0, 32'h4};
    l4_data = '{32'hAAAA0000, 32'hBBBB1111, 32'h0, 32'h0};
    l4_wr   = '{1, 1, 0, 0};

    resetn = 1'b0; stall = 1'b0; size = 2'd2;
    req4 = 1'b0; wr4 = 1'b0; addr4 = '0; wdata4 = '0; wstrb4 = 4'hF;
    stall4 = 1'b0; size4 = 2'd2;

    // Reset state, with req asserted to show it is ignored
    drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    expect_resp("reset", 1'b0, 1'b0, 32'h0);
    check("reset.dut4.addr_ok", {31'b0, addr_ok4}, 32'h0);
    check("reset.dut4.data_ok", {31'b0, data_ok4}, 32'h0);
    next_cycle();
    resetn = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    expect_resp("post_reset", 1'b1, 1'b0, 32'h0);
    next_cycle();

    // Full-queue hold-off with LATENCY=4
    k = 0;
    for (int c = 0; c < 11; c++) begin
      req4 = (k < 4); wr4 = l4_wr[k % 4]; addr4 = l4_addr[k % 4];
      wdata4 = l4_data[k % 4];
      @(negedge clk);
      check($sformatf("lat4.c%0d.addr_ok", c), {31'b0, addr_ok4}, {31'b0, e4_ao[c]});
      check($sformatf("lat4.c%0d.data_ok", c), {31'b0, data_ok4}, {31'b0, e4_dok[c]});
      check($sformatf("lat4.c%0d.rdata", c), rdata4, e4_rd[c]);
      if (req4 && addr_ok4) k++;
      next_cycle();
    end
    req4 = 1'b0;

    // Write then read the same word
    drive(1'b1, 1'b1, 32'h1C000000, 32'h12345678, 4'hF);
    expect_resp("wr_rd.c0", 1'b1, 1'b0, 32'h0);
    next_cycle();
    drive(1'b1, 1'b0, 32'h1C000000, 32'h0, 4'h0);
    expect_resp("wr_rd.c1", 1'b1, 1'b0, 32'h0);
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    expect_resp("wr_rd.c2", 1'b1, 1'b1, 32'h0);
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    expect_resp("wr_rd.c3", 1'b1, 1'b1, 32'h12345678);
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    expect_resp("wr_rd.c4", 1'b1, 1'b0, 32'h0);
    next_cycle();

    // Partial write, then zero-strobe write and an aliased read
    drive(1'b1, 1'b1, 32'h10, 32'hFFFFFFFF, 4'hF);
    expect_resp("part.c0", 1'b1, 1'b0, 32'h0);
    next_cycle();
    drive(1'b1, 1'b1, 32'h10, 32'h000000AA, 4'h1);
    expect_resp("part.c1", 1'b1, 1'b0, 32'h0);
    next_cycle();
    drive(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    expect_resp("part.c2", 1'b1, 1'b1, 32'h0);
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    expect_resp("part.c3", 1'b1, 1'b1, 32'h0);
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    expect_resp("part.c4", 1'b1, 1'b1, 32'hFFFFFFAA);
    next_cycle();
    drive(1'b1, 1'b1, 32'h10, 32'h00000000, 4'h0);
    expect_resp("nostrb.c5", 1'b1, 1'b0, 32'h0);
    next_cycle();
    drive(1'b1, 1'b0, 32'hF0004013, 32'h0, 4'h0);
    expect_resp("nostrb.c6", 1'b1, 1'b0, 32'h0);
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    expect_resp("nostrb.c7", 1'b1, 1'b1, 32'h0);
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    expect_resp("nostrb.c8", 1'b1, 1'b1, 32'hFFFFFFAA);
    next_cycle();

    // 6 writes then 6 reads with req held high throughout
    for (int c = 0; c < 14; c++) begin
      if (c < 6)
        drive(1'b1, 1'b1, 32'(c * 4), 32'hC0DE0000 + 32'(c * 32'h111), 4'hF);
      else if (c < 12)
        drive(1'b1, 1'b0, 32'((c - 6) * 4), 32'h0, 4'h0);
      else
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      expect_resp($sformatf("stream.c%0d", c), 1'b1, (c >= 2),
                  (c >= 8) ? 32'hC0DE0000 + 32'((c - 8) * 32'h111) : 32'h0);
      next_cycle();
    end

    // Reset with two reads pending: no responses, memory kept
    drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    expect_resp("rst_mid.c0", 1'b1, 1'b0, 32'h0);
    next_cycle();
    drive(1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
    expect_resp("rst_mid.c1", 1'b1, 1'b0, 32'h0);
    next_cycle();
    resetn = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    expect_resp("rst_mid.c2", 1'b0, 1'b0, 32'h0);
    next_cycle();
    resetn = 1'b1;
    for (int c = 3; c < 6; c++) begin
      drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      expect_resp($sformatf("rst_mid.c%0d", c), 1'b1, 1'b0, 32'h0);
      next_cycle();
    end
    drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    expect_resp("rst_mem.c0", 1'b1, 1'b0, 32'h0);
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    expect_resp("rst_mem.c1", 1'b1, 1'b0, 32'h0);
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    expect_resp("rst_mem.c2", 1'b1, 1'b1, 32'hC0DE0000);
    next_cycle();

    // Stall holds off acceptance but not a pending response
    drive(1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
    expect_resp("stall.c0", 1'b1, 1'b0, 32'h0);
    next_cycle();
    stall = 1'b1;
    for (int c = 1; c < 4; c++) begin
      drive(1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
      expect_resp($sformatf("stall.c%0d", c), 1'b0, (c == 2),
                  (c == 2) ? 32'hC0DE0222 : 32'h0);
      next_cycle();
    end
    stall = 1'b0;
    drive(1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
    expect_resp("stall.c4", 1'b1, 1'b0, 32'h0);
    next_cycle();
    for (int c = 5; c < 8; c++) begin
      drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      expect_resp($sformatf("stall.c%0d", c), 1'b1, (c == 6),
                  (c == 6) ? 32'hC0DE0111 : 32'h0);
      next_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
